xor4_parity_arbiter: RTL and testbench

XOR4_PARITY_ARBITER -- requirements
Module: xor4_parity_arbiter

---
 rtl/xor4_parity_arbiter.sv | 161 ++++++++++++++++
 tb/tb_xor4_parity_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/xor4_parity_arbiter.sv
// xor4_parity_arbiter
//   Grants one of four requesters at a time, round-robin, for a multi-word
//   frame. Each accepted word is routed to a shared external XOR4 gate. The
//   gate result is folded into a running parity bit. When the frame ends, a
//   registered result (id, parity, word count, error) is held until the
//   consumer accepts it.
//
//   State table
//   IDLE   | no owner; arbitrate among i_req, clear accumulator and count
//   BURST  | owner granted; accept words while i_req[owner] is high
//   RESULT | frame summary presented on o_res_*, waiting for i_res_ready
//
// Ports
//   i_clk, i_rst_n      clock, async active-low reset
//   i_req[3:0]          per-requester frame request
//   i_data[15:0]        4-bit word per requester (k on [4k+3:4k])
//   i_last[3:0]         per-requester last-word marker
//   o_gnt[3:0]          one-hot grant, also the owner's ready
//   o_xor_a..d          operands to the external XOR4 gate
//   i_xor_f             XOR4 gate result
//   o_res_valid/_id/_parity/_words/_err, i_res_ready   result handshake
module xor4_parity_arbiter #(
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_req,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_last,
  output logic [3:0]  o_gnt,
  output logic        o_xor_a,
  output logic        o_xor_b,
  output logic        o_xor_c,
  output logic        o_xor_d,
  input  logic        i_xor_f,
  output logic        o_res_valid,
  output logic [1:0]  o_res_id,
  output logic        o_res_parity,
  output logic [7:0]  o_res_words,
  output logic        o_res_err,
  input  logic        i_res_ready
);

  typedef enum logic [1:0] {IDLE, BURST, RESULT} state_t;

  localparam logic [7:0] MaxWords = 8'(MAX_WORDS);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_winner_q, last_winner_d;
  logic       acc_q, acc_d;
  logic [7:0] count_q, count_d;
  logic       err_q, err_d;

  logic [1:0] rr_cand;
  logic [1:0] rr_pick;
  logic       rr_found;
  logic [3:0] owner_slice;
  logic [7:0] count_inc;

  // Round-robin search starting one past the previous winner; i = 4 wraps
  // back to last_winner itself so a lone repeat requester still wins.
  always_comb begin
    rr_pick  = 2'd0;
    rr_found = 1'b0;
    rr_cand  = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      rr_cand = last_winner_q + i[1:0];
      if (!rr_found && i_req[rr_cand]) begin
        rr_pick  = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    case (owner_q)
      2'd0:    owner_slice = i_data[3:0];
      2'd1:    owner_slice = i_data[7:4];
      2'd2:    owner_slice = i_data[11:8];
      default: owner_slice = i_data[15:12];
    endcase
  end

  assign count_inc = count_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    acc_d         = acc_q;
    count_d       = count_q;
    err_d         = err_q;
    o_gnt         = 4'b0000;
    {o_xor_a, o_xor_b, o_xor_c, o_xor_d} = 4'b0000;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          owner_d = rr_pick;
          acc_d   = 1'b0;
          count_d = 8'd0;
          err_d   = 1'b0;
          state_d = BURST;
        end
      end
      BURST: begin
        o_gnt = 4'b0001 << owner_q;
        {o_xor_a, o_xor_b, o_xor_c, o_xor_d} = owner_slice;
        if (i_req[owner_q]) begin
          acc_d   = acc_q ^ i_xor_f;
          count_d = count_inc;
          // i_last takes precedence over the word-limit error on the same word
          if (i_last[owner_q]) begin
            err_d   = 1'b0;
            state_d = RESULT;
          end else if (count_inc == MaxWords) begin
            err_d   = 1'b1;
            state_d = RESULT;
          end
        end
      end
      RESULT: begin
        if (i_res_ready) begin
          last_winner_d = owner_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result fields come straight from registers, gated so they read 0
  // whenever no result is being presented.
  always_comb begin
    o_res_valid  = (state_q == RESULT);
    o_res_id     = o_res_valid ? owner_q : 2'd0;
    o_res_parity = o_res_valid & acc_q;
    o_res_words  = o_res_valid ? count_q : 8'd0;
    o_res_err    = o_res_valid & err_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 2'd0;
      last_winner_q <= 2'd3;
      acc_q         <= 1'b0;
      count_q       <= 8'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_xor4_parity_arbiter.sv
module tb_xor4_parity_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_req;
  logic [15:0] i_data;
  logic [3:0]  i_last;
  logic [3:0]  o_gnt;
  logic        o_xor_a, o_xor_b, o_xor_c, o_xor_d;
  logic        i_xor_f;
  logic        o_res_valid;
  logic [1:0]  o_res_id;
  logic        o_res_parity;
  logic [7:0]  o_res_words;
  logic        o_res_err;
  logic        i_res_ready;

  int checks = 0;
  int passed = 0;

  always #5 i_clk = ~i_clk;

  // External XOR4 gate
  assign i_xor_f = o_xor_a ^ o_xor_b ^ o_xor_c ^ o_xor_d;

  xor4_parity_arbiter #(.MAX_WORDS(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_data(i_data),
    .i_last(i_last), .o_gnt(o_gnt), .o_xor_a(o_xor_a), .o_xor_b(o_xor_b),
    .o_xor_c(o_xor_c), .o_xor_d(o_xor_d), .i_xor_f(i_xor_f),
    .o_res_valid(o_res_valid), .o_res_id(o_res_id), .o_res_parity(o_res_parity),
    .o_res_words(o_res_words), .o_res_err(o_res_err), .i_res_ready(i_res_ready)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  last;
    logic        ready;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [20:0] pk(logic [3:0] g, logic [3:0] x, logic v,
                                     logic [1:0] id, logic p, logic [7:0] w, logic e);
    return {g, x, v, id, p, w, e};
  endfunction

  task automatic add(logic [3:0] req, logic [15:0] data, logic [3:0] last,
                     logic ready, logic [20:0] exp);
    vec_t v;
    v.req = req; v.data = data; v.last = last; v.ready = ready; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(logic [3:0] req, logic [15:0] data, logic [3:0] last, logic ready);
    i_req = req; i_data = data; i_last = last; i_res_ready = ready;
  endtask

  task automatic chk(string nm, logic [20:0] exp);
    logic [20:0] obs;
    obs = {o_gnt, o_xor_a, o_xor_b, o_xor_c, o_xor_d, o_res_valid, o_res_id,
           o_res_parity, o_res_words, o_res_err};
    checks++;
    if (obs !== exp)
      $display("FAIL %s: got gnt=%b xor=%b v=%b id=%0d p=%b w=%0d e=%b, expected gnt=%b xor=%b v=%b id=%0d p=%b w=%0d e=%b",
               nm, obs[20:17], obs[16:13], obs[12], obs[11:10], obs[9], obs[8:1], obs[0],
               exp[20:17], exp[16:13], exp[12], exp[11:10], exp[9], exp[8:1], exp[0]);
    else
      passed++;
  endtask

  localparam logic [20:0] ZERO = 21'd0;

  initial begin
    // Round-robin 1-word frames from reset: order 0,1,2,3,0
    // slices of 16'h7310: r0=0000 r1=0001 r2=0011 r3=0111
    add(4'hF, 16'h7310, 4'hF, 1'b1, ZERO);
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b0001, 4'b0000, 0, 0, 0, 0, 0));
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b0000, 4'b0000, 1, 0, 0, 1, 0));
    add(4'hF, 16'h7310, 4'hF, 1'b1, ZERO);
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b0010, 4'b0001, 0, 0, 0, 0, 0));
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b0000, 4'b0000, 1, 1, 1, 1, 0));
    add(4'hF, 16'h7310, 4'hF, 1'b1, ZERO);
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b0100, 4'b0011, 0, 0, 0, 0, 0));
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b0000, 4'b0000, 1, 2, 0, 1, 0));
    add(4'hF, 16'h7310, 4'hF, 1'b1, ZERO);
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b1000, 4'b0111, 0, 0, 0, 0, 0));
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b0000, 4'b0000, 1, 3, 1, 1, 0));
    add(4'hF, 16'h7310, 4'hF, 1'b1, ZERO);
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b0001, 4'b0000, 0, 0, 0, 0, 0));
    add(4'hF, 16'h7310, 4'hF, 1'b1, pk(4'b0000, 4'b0000, 1, 0, 0, 1, 0));
    // Requester 0: 1011 then 0110(last); non-owner data/last are noise
    add(4'b0001, 16'h0000, 4'b0000, 1'b0, ZERO);
    add(4'b0001, 16'hA5AB, 4'b1110, 1'b0, pk(4'b0001, 4'b1011, 0, 0, 0, 0, 0));
    add(4'b0001, 16'h5F56, 4'b0001, 1'b0, pk(4'b0001, 4'b0110, 0, 0, 0, 0, 0));
    // Result held 4 cycles with ready low while requester 1 waits
    add(4'b0010, 16'h0000, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 1, 0, 1, 2, 0));
    add(4'b0010, 16'h0000, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 1, 0, 1, 2, 0));
    add(4'b0010, 16'h0000, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 1, 0, 1, 2, 0));
    add(4'b0010, 16'h0000, 4'b0000, 1'b0, pk(4'b0000, 4'b0000, 1, 0, 1, 2, 0));
    add(4'b0010, 16'h0000, 4'b0000, 1'b1, pk(4'b0000, 4'b0000, 1, 0, 1, 2, 0));
    add(4'b0010, 16'h0000, 4'b0000, 1'b1, ZERO);
    // Requester 1: word 1001, 5-cycle stall, then 0111(last)
    add(4'b0010, 16'h0090, 4'b0000, 1'b0, pk(4'b0010, 4'b1001, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      add(4'b1101, 16'hFFFF, 4'b1111, 1'b0, pk(4'b0010, 4'b1111, 0, 0, 0, 0, 0));
    add(4'b0010, 16'h0070, 4'b0010, 1'b0, pk(4'b0010, 4'b0111, 0, 0, 0, 0, 0));
    add(4'b0000, 16'h0000, 4'b0000, 1'b1, pk(4'b0000, 4'b0000, 1, 1, 1, 2, 0));
    // Requester 2: 1111 x3 without last, MAX_WORDS=3 -> error
    add(4'b0100, 16'h0000, 4'b0000, 1'b0, ZERO);
    add(4'b0100, 16'h0F00, 4'b1011, 1'b0, pk(4'b0100, 4'b1111, 0, 0, 0, 0, 0));
    add(4'b0100, 16'h0F00, 4'b1011, 1'b0, pk(4'b0100, 4'b1111, 0, 0, 0, 0, 0));
    add(4'b0100, 16'h0F00, 4'b1011, 1'b0, pk(4'b0100, 4'b1111, 0, 0, 0, 0, 0));
    add(4'b0000, 16'h0000, 4'b0000, 1'b1, pk(4'b0000, 4'b0000, 1, 2, 0, 3, 1));
    // Requester 3: last arrives on the MAX_WORDS-th word -> no error
    add(4'b1000, 16'h0000, 4'b0000, 1'b0, ZERO);
    add(4'b1000, 16'h1000, 4'b0000, 1'b0, pk(4'b1000, 4'b0001, 0, 0, 0, 0, 0));
    add(4'b1000, 16'h3000, 4'b0000, 1'b0, pk(4'b1000, 4'b0011, 0, 0, 0, 0, 0));
    add(4'b1000, 16'h1000, 4'b1000, 1'b0, pk(4'b1000, 4'b0001, 0, 0, 0, 0, 0));
    add(4'b0000, 16'h0000, 4'b0000, 1'b1, pk(4'b0000, 4'b0000, 1, 3, 0, 3, 0));
    add(4'b0000, 16'h0000, 4'b0000, 1'b0, ZERO);

    // Reset with requests pending: all outputs 0
    i_rst_n = 1'b0;
    drive(4'hF, 16'hFFFF, 4'hF, 1'b1);
    repeat (2) @(negedge i_clk);
    #1 chk("reset_outputs", ZERO);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].data, tbl[i].last, tbl[i].ready);
      #1 chk($sformatf("vec%0d", i), tbl[i].exp);
      @(negedge i_clk);
    end

    // 1-word frame by requester 0 so last_winner becomes 0
    drive(4'b0001, 16'h0000, 4'b0001, 1'b1);
    #1 chk("pre_idle", ZERO);
    @(negedge i_clk);
    #1 chk("pre_gnt0", pk(4'b0001, 4'b0000, 0, 0, 0, 0, 0));
    @(negedge i_clk);
    #1 chk("pre_res0", pk(4'b0000, 4'b0000, 1, 0, 0, 1, 0));
    @(negedge i_clk);
    // With last_winner=0, requester 3 beats 0
    drive(4'b1001, 16'hE00E, 4'b0000, 1'b0);
    #1 chk("rr_idle", ZERO);
    @(negedge i_clk);
    #1 chk("rr_gnt3", pk(4'b1000, 4'b1110, 0, 0, 0, 0, 0));
    // Async reset mid-BURST, checked before the next rising edge
    #1 i_rst_n = 1'b0;
    #1 chk("async_rst", ZERO);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 chk("post_rst_idle", ZERO);
    @(negedge i_clk);
    #1 chk("post_rst_gnt0", pk(4'b0001, 4'b1110, 0, 0, 0, 0, 0));
    i_last = 4'b0001;
    i_res_ready = 1'b1;
    @(negedge i_clk);
    #1 chk("post_rst_res", pk(4'b0000, 4'b0000, 1, 0, 1, 1, 0));
    @(negedge i_clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
